// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU data port, debug/loader port),
// the arbiter and the single-port data memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port data memory: grants CPU or debug port,
// sequences the access with WAIT_CYCLES wait states and pulses a one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mem_port_arbiter_if.slave    bus,
    output logic                 o_busy,
    output logic                 o_owner
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic        RR    = (CPU_PRIORITY == 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_cpu_ack;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_busy;

    logic [1:0]        w_state_nx;
    logic              w_owner_nx;
    logic              w_we_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [DATA_W-1:0] w_wdata_nx;
    logic              w_mem_rd_nx;
    logic              w_mem_wr_nx;
    logic              w_cpu_ack_nx;
    logic              w_dbg_ack_nx;
    logic [DATA_W-1:0] w_cpu_rdata_nx;
    logic [DATA_W-1:0] w_dbg_rdata_nx;
    logic              w_busy_nx;
    logic              w_pick_dbg;
    logic              w_last_cycle;

    // On a tie the debug port wins only in round-robin mode when the CPU was last served
    assign w_pick_dbg   = bus.dbg_req & (~bus.cpu_req | (RR & ~r_owner));
    assign w_last_cycle = (r_cnt == '0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state, latched request copy and registered outputs
    always_comb begin
        w_state_nx     = r_state;
        w_owner_nx     = r_owner;
        w_we_nx        = r_we;
        w_cnt_nx       = r_cnt;
        w_addr_nx      = r_mem_addr;
        w_wdata_nx     = r_mem_wdata;
        w_cpu_ack_nx   = 1'b0;
        w_dbg_ack_nx   = 1'b0;
        w_cpu_rdata_nx = r_cpu_rdata;
        w_dbg_rdata_nx = r_dbg_rdata;

        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    w_state_nx = S_ACCESS;
                    w_owner_nx = w_pick_dbg;
                    w_we_nx    = w_pick_dbg ? bus.dbg_we    : bus.cpu_we;
                    w_addr_nx  = w_pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
                    w_wdata_nx = w_pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                    w_cnt_nx   = CNT_W'(WAIT_CYCLES);
                end
            end
            S_ACCESS: begin
                if (w_last_cycle) begin
                    w_state_nx = S_ACK;
                    if (!r_we) begin
                        if (r_owner) begin
                            w_dbg_rdata_nx = bus.mem_rdata;
                        end else begin
                            w_cpu_rdata_nx = bus.mem_rdata;
                        end
                    end
                    w_cpu_ack_nx = ~r_owner;
                    w_dbg_ack_nx = r_owner;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            S_ACK: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Strobes are registered one cycle ahead so they line up with the ACCESS cycles
        w_busy_nx   = (w_state_nx != S_IDLE);
        w_mem_rd_nx = (w_state_nx == S_ACCESS) & ~w_we_nx;
        w_mem_wr_nx = (w_state_nx == S_ACCESS) & w_we_nx & (w_cnt_nx == '0);
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner     <= 1'b1;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_owner     <= w_owner_nx;
            r_we        <= w_we_nx;
            r_cnt       <= w_cnt_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_wdata <= w_wdata_nx;
            r_mem_rd    <= w_mem_rd_nx;
            r_mem_wr    <= w_mem_wr_nx;
            r_cpu_ack   <= w_cpu_ack_nx;
            r_dbg_ack   <= w_dbg_ack_nx;
            r_cpu_rdata <= w_cpu_rdata_nx;
            r_dbg_rdata <= w_dbg_rdata_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;
    assign o_busy        = r_busy;
    assign o_owner       = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: five instances cover the wait-state / priority
// configurations; a queue of expected (port, rdata) is popped on every ack.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t exp_q[$];

    mem_port_arbiter_if bus0 ();
    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus2 ();
    mem_port_arbiter_if bus3 ();
    mem_port_arbiter_if bus4 ();
    logic busy0, busy1, busy2, busy3, busy4;
    logic owner0, owner1, owner2, owner3, owner4;

    mem_port_arbiter #(.WAIT_CYCLES(1), .CPU_PRIORITY(0)) u0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0), .o_busy(busy0), .o_owner(owner0));
    mem_port_arbiter #(.WAIT_CYCLES(1), .CPU_PRIORITY(1)) u1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1), .o_busy(busy1), .o_owner(owner1));
    mem_port_arbiter #(.WAIT_CYCLES(0), .CPU_PRIORITY(0)) u2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2), .o_busy(busy2), .o_owner(owner2));
    mem_port_arbiter #(.WAIT_CYCLES(3), .CPU_PRIORITY(0)) u3 (
        .i_clk(clk), .i_rst(rst), .bus(bus3), .o_busy(busy3), .o_owner(owner3));
    mem_port_arbiter #(.WAIT_CYCLES(2), .CPU_PRIORITY(0)) u4 (
        .i_clk(clk), .i_rst(rst), .bus(bus4), .o_busy(busy4), .o_owner(owner4));

    // Memory models: u0 gets a real RAM, u2 a driven value, u3/u4 only log writes
    logic [31:0] mem0 [256];
    logic [31:0] mem2_rdata = 32'h0;
    int          wr3_cnt = 0;
    int          wr4_cnt = 0;
    logic [31:0] wr4_addr = 32'h0;
    logic [31:0] wr4_data = 32'h0;

    always @(posedge clk) if (bus0.mem_wr) mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
    assign bus0.mem_rdata = mem0[bus0.mem_addr[7:0]];
    assign bus1.mem_rdata = 32'h0;
    assign bus2.mem_rdata = mem2_rdata;
    assign bus3.mem_rdata = 32'h0;
    assign bus4.mem_rdata = 32'h0;
    always @(posedge clk) if (bus3.mem_wr) wr3_cnt <= wr3_cnt + 1;
    always @(posedge clk) begin
        if (bus4.mem_wr) begin
            wr4_cnt  <= wr4_cnt + 1;
            wr4_addr <= bus4.mem_addr;
            wr4_data <= bus4.mem_wdata;
        end
    end

    task automatic init_bus();
        bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
        bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
        bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = 0; bus1.dbg_wdata = 0;
        bus2.cpu_req = 0; bus2.cpu_we = 0; bus2.cpu_addr = 0; bus2.cpu_wdata = 0;
        bus2.dbg_req = 0; bus2.dbg_we = 0; bus2.dbg_addr = 0; bus2.dbg_wdata = 0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
        bus3.dbg_req = 0; bus3.dbg_we = 0; bus3.dbg_addr = 0; bus3.dbg_wdata = 0;
        bus4.cpu_req = 0; bus4.cpu_we = 0; bus4.cpu_addr = 0; bus4.cpu_wdata = 0;
        bus4.dbg_req = 0; bus4.dbg_we = 0; bus4.dbg_addr = 0; bus4.dbg_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({bus0.mem_rd, bus0.mem_wr, bus0.cpu_ack, bus0.dbg_ack, busy0} !== 5'b0)
            $display("FAIL rst_ctrl: got %b expected 00000", {bus0.mem_rd, bus0.mem_wr, bus0.cpu_ack, bus0.dbg_ack, busy0}); else n_pass++;
        n_chk++; if ({bus0.mem_addr, bus0.mem_wdata} !== 64'h0)
            $display("FAIL rst_mem_bus: got %h expected 0", {bus0.mem_addr, bus0.mem_wdata}); else n_pass++;
        n_chk++; if ({bus0.cpu_rdata, bus0.dbg_rdata} !== 64'h0)
            $display("FAIL rst_rdata: got %h expected 0", {bus0.cpu_rdata, bus0.dbg_rdata}); else n_pass++;
        n_chk++; if ({owner0, owner1, owner2, owner3, owner4} !== 5'b11111)
            $display("FAIL rst_owner: got %b expected 11111", {owner0, owner1, owner2, owner3, owner4}); else n_pass++;
    endtask

    task automatic test_write_read();
        int n; int wr_n; int rd_n; int stall_bad; bit got; exp_t e;
        // Write 0x10 <= 0xDEADBEEF
        @(negedge clk);
        bus0.cpu_we = 1; bus0.cpu_addr = 32'h10; bus0.cpu_wdata = 32'hDEADBEEF; bus0.cpu_req = 1;
        exp_q.push_back({1'b0, 32'h0, 1'b0});
        n = 0; wr_n = 0; stall_bad = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (bus0.mem_wr) wr_n++;
            if (bus0.cpu_ack || bus0.dbg_ack) got = 1;
            else if (bus0.cpu_stall !== 1'b1) stall_bad++;
        end
        n_chk++; if (!got) $display("FAIL wr_timeout: got no ack expected ack"); else n_pass++;
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++; if (bus0.dbg_ack !== e.port || bus0.cpu_ack !== ~e.port)
                $display("FAIL wr_port: got cpu_ack=%b dbg_ack=%b expected port %0d", bus0.cpu_ack, bus0.dbg_ack, e.port); else n_pass++;
        end
        n_chk++; if (n !== 3) $display("FAIL wr_latency: got %0d expected 3", n); else n_pass++;
        n_chk++; if (wr_n !== 1) $display("FAIL wr_strobe: got %0d cycles expected 1", wr_n); else n_pass++;
        n_chk++; if (stall_bad !== 0 || bus0.cpu_stall !== 1'b0)
            $display("FAIL wr_stall: got %0d bad cycles, stall_at_ack=%b expected 0", stall_bad, bus0.cpu_stall); else n_pass++;
        bus0.cpu_req = 0;
        @(negedge clk);
        n_chk++; if (mem0[8'h10] !== 32'hDEADBEEF) $display("FAIL wr_mem: got %h expected deadbeef", mem0[8'h10]); else n_pass++;
        // Read it back
        bus0.cpu_we = 0; bus0.cpu_wdata = 32'h0; bus0.cpu_req = 1;
        exp_q.push_back({1'b0, 32'hDEADBEEF, 1'b1});
        n = 0; wr_n = 0; rd_n = 0; stall_bad = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (bus0.mem_wr) wr_n++;
            if (bus0.mem_rd) rd_n++;
            if (bus0.cpu_ack || bus0.dbg_ack) got = 1;
            else if (bus0.cpu_stall !== 1'b1) stall_bad++;
        end
        n_chk++; if (!got) $display("FAIL rd_timeout: got no ack expected ack"); else n_pass++;
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++; if (bus0.cpu_ack !== 1'b1 || bus0.cpu_rdata !== e.rdata)
                $display("FAIL rd_data: got ack=%b rdata=%h expected ack=1 rdata=%h", bus0.cpu_ack, bus0.cpu_rdata, e.rdata); else n_pass++;
        end
        n_chk++; if (n !== 3) $display("FAIL rd_latency: got %0d expected 3", n); else n_pass++;
        n_chk++; if (rd_n !== 2 || wr_n !== 0)
            $display("FAIL rd_strobes: got rd=%0d wr=%0d expected rd=2 wr=0", rd_n, wr_n); else n_pass++;
        n_chk++; if (stall_bad !== 0) $display("FAIL rd_stall: got %0d bad cycles expected 0", stall_bad); else n_pass++;
        bus0.cpu_req = 0;
        @(negedge clk);
    endtask

    // Both ports held high: round-robin gives C,D,C,D starting from reset
    task automatic test_tie_round_robin();
        int n; int acks; exp_t e;
        do_reset();
        bus0.cpu_we = 0; bus0.cpu_addr = 32'h10;
        bus0.dbg_we = 0; bus0.dbg_addr = 32'h10;
        bus0.cpu_req = 1; bus0.dbg_req = 1;
        exp_q.push_back({1'b0, 32'hDEADBEEF, 1'b1});
        exp_q.push_back({1'b1, 32'hDEADBEEF, 1'b1});
        exp_q.push_back({1'b0, 32'hDEADBEEF, 1'b1});
        exp_q.push_back({1'b1, 32'hDEADBEEF, 1'b1});
        n = 0; acks = 0;
        while (acks < 4 && n < 60) begin
            @(negedge clk); n++;
            if ((bus0.cpu_ack || bus0.dbg_ack) && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                acks++;
                n_chk++; if ({bus0.cpu_ack, bus0.dbg_ack} !== {~e.port, e.port})
                    $display("FAIL tie_order_%0d: got cpu_ack=%b dbg_ack=%b expected port %0d", acks, bus0.cpu_ack, bus0.dbg_ack, e.port); else n_pass++;
                n_chk++; if ((e.port ? bus0.dbg_rdata : bus0.cpu_rdata) !== e.rdata)
                    $display("FAIL tie_rdata_%0d: got %h expected %h", acks, e.port ? bus0.dbg_rdata : bus0.cpu_rdata, e.rdata); else n_pass++;
            end
        end
        n_chk++; if (acks !== 4) $display("FAIL tie_timeout: got %0d acks expected 4", acks); else n_pass++;
        bus0.cpu_req = 0; bus0.dbg_req = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_cpu_priority();
        int n; int acks; int dbg_n; exp_t e;
        bus1.cpu_we = 1; bus1.cpu_addr = 32'h40; bus1.cpu_wdata = 32'h11;
        bus1.dbg_we = 1; bus1.dbg_addr = 32'h44; bus1.dbg_wdata = 32'h22;
        bus1.cpu_req = 1; bus1.dbg_req = 1;
        repeat (3) exp_q.push_back({1'b0, 32'h0, 1'b0});
        n = 0; acks = 0; dbg_n = 0;
        while (acks < 3 && n < 40) begin
            @(negedge clk); n++;
            if (bus1.dbg_ack) dbg_n++;
            if ((bus1.cpu_ack || bus1.dbg_ack) && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                acks++;
                n_chk++; if ({bus1.cpu_ack, bus1.dbg_ack} !== {~e.port, e.port})
                    $display("FAIL prio_grant_%0d: got cpu_ack=%b dbg_ack=%b expected port %0d", acks, bus1.cpu_ack, bus1.dbg_ack, e.port); else n_pass++;
            end
        end
        n_chk++; if (acks !== 3 || dbg_n !== 0)
            $display("FAIL prio_starve: got acks=%0d dbg_acks=%0d expected 3 and 0", acks, dbg_n); else n_pass++;
        bus1.cpu_req = 0; bus1.dbg_req = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero_wait_read();
        int n; int rd_n; bit got; exp_t e;
        // Seed cpu_rdata so the debug read can be shown not to disturb it
        @(negedge clk);
        mem2_rdata = 32'hAAAA5555;
        bus2.cpu_we = 0; bus2.cpu_addr = 32'h0; bus2.cpu_req = 1;
        n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            if (bus2.cpu_ack) got = 1;
        end
        n_chk++; if (!got || bus2.cpu_rdata !== 32'hAAAA5555)
            $display("FAIL w0_cpu_rd: got ack=%b rdata=%h expected ack=1 rdata=aaaa5555", got, bus2.cpu_rdata); else n_pass++;
        bus2.cpu_req = 0;
        @(negedge clk);
        mem2_rdata = 32'h1234;
        bus2.dbg_we = 0; bus2.dbg_addr = 32'h4; bus2.dbg_req = 1;
        exp_q.push_back({1'b1, 32'h1234, 1'b1});
        n = 0; rd_n = 0; got = 0;
        while (!got && n < 10) begin
            @(negedge clk); n++;
            if (bus2.mem_rd) rd_n++;
            if (bus2.cpu_ack || bus2.dbg_ack) got = 1;
        end
        n_chk++; if (!got) $display("FAIL w0_timeout: got no ack expected ack"); else n_pass++;
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++; if (bus2.dbg_ack !== 1'b1 || bus2.cpu_ack !== 1'b0 || bus2.dbg_rdata !== e.rdata)
                $display("FAIL w0_dbg_rd: got dbg_ack=%b cpu_ack=%b rdata=%h expected 1 0 %h", bus2.dbg_ack, bus2.cpu_ack, bus2.dbg_rdata, e.rdata); else n_pass++;
        end
        n_chk++; if (n !== 2) $display("FAIL w0_latency: got %0d expected 2", n); else n_pass++;
        n_chk++; if (bus2.cpu_rdata !== 32'hAAAA5555)
            $display("FAIL w0_cpu_hold: got %h expected aaaa5555", bus2.cpu_rdata); else n_pass++;
        n_chk++; if (bus2.mem_addr !== 32'h4 || rd_n !== 1)
            $display("FAIL w0_addr: got addr=%h rd_cycles=%0d expected 4 and 1", bus2.mem_addr, rd_n); else n_pass++;
        bus2.dbg_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int ack_n; int wr_before; logic busy_mid;
        @(negedge clk);
        wr_before = wr3_cnt;
        bus3.cpu_we = 1; bus3.cpu_addr = 32'h30; bus3.cpu_wdata = 32'h55AA55AA; bus3.cpu_req = 1;
        @(negedge clk);
        @(negedge clk);
        busy_mid = busy3;
        rst = 1'b1; bus3.cpu_req = 0;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (busy_mid !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy_mid); else n_pass++;
        n_chk++; if ({busy3, bus3.mem_wr, bus3.cpu_ack} !== 3'b000)
            $display("FAIL rstmid_after: got busy/wr/ack=%b expected 000", {busy3, bus3.mem_wr, bus3.cpu_ack}); else n_pass++;
        ack_n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus3.cpu_ack || bus3.dbg_ack) ack_n++;
        end
        n_chk++; if (ack_n !== 0 || wr3_cnt !== wr_before)
            $display("FAIL rstmid_discard: got acks=%0d writes=%0d expected 0 and 0", ack_n, wr3_cnt - wr_before); else n_pass++;
    endtask

    task automatic test_drop_mid_write();
        int n; int ack_n; int wr_before; bit got;
        @(negedge clk);
        wr_before = wr4_cnt;
        bus4.cpu_we = 1; bus4.cpu_addr = 32'h8; bus4.cpu_wdata = 32'hCAFEF00D; bus4.cpu_req = 1;
        exp_q.push_back({1'b0, 32'h0, 1'b0});
        n = 0; got = 0; ack_n = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (n == 2) bus4.cpu_req = 0;
            if (bus4.cpu_ack || bus4.dbg_ack) begin got = 1; ack_n++; end
        end
        n_chk++; if (!got || exp_q.size() == 0) $display("FAIL drop_timeout: got no ack expected ack"); else begin
            n_pass++;
            void'(exp_q.pop_front());
        end
        n_chk++; if (n !== 4) $display("FAIL drop_latency: got %0d expected 4", n); else n_pass++;
        repeat (6) begin
            @(negedge clk);
            if (bus4.cpu_ack || bus4.dbg_ack) ack_n++;
        end
        n_chk++; if (ack_n !== 1) $display("FAIL drop_ack_count: got %0d expected 1", ack_n); else n_pass++;
        n_chk++; if (wr4_cnt - wr_before !== 1 || wr4_addr !== 32'h8 || wr4_data !== 32'hCAFEF00D)
            $display("FAIL drop_commit: got writes=%0d addr=%h data=%h expected 1 8 cafef00d", wr4_cnt - wr_before, wr4_addr, wr4_data); else n_pass++;
        n_chk++; if (busy4 !== 1'b0) $display("FAIL drop_idle: got busy=%b expected 0", busy4); else n_pass++;
    endtask

    initial begin
        init_bus();
        test_reset();
        test_write_read();
        test_tie_round_robin();
        test_cpu_priority();
        test_zero_wait_read();
        test_reset_mid_access();
        test_drop_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
